axi_stream_packet_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one downstream AXI-stream datapath (typically the wide 72–95 bit stream cache FIFO) between NUM upstream requesters. A grant is held for a whole packet and released only after the beat carrying tlast is accepted downstream. Single clock domain; it sits directly in front of the cache's write side.

---
 rtl/axi_stream_packet_arbiter.sv | 97 +++++++++
 tb/tb_axi_stream_packet_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_packet_arbiter.sv
// Packet-level round-robin arbiter for the wide AXI-stream cache FIFO.
// A grant is held from first beat until the tlast handshake.
module axi_stream_packet_arbiter #(
  parameter int NUM   = 4,
  parameter int DSIZE = 88,
  parameter int IDW   = $clog2(NUM)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM*DSIZE-1:0] s_tdata,
  input  logic [NUM-1:0]       s_tvalid,
  input  logic [NUM-1:0]       s_tlast,
  output logic [NUM-1:0]       s_tready,
  output logic [DSIZE-1:0]     m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic [IDW-1:0]       m_tid,
  output logic                 busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] win;
  logic [IDW-1:0] sel;
  logic           found;
  int             idx;

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NUM; k++) begin
      idx = (int'(last_q) + 1 + k) % NUM;
      sel = IDW'(idx);
      if (!found && s_tvalid[sel]) begin
        win   = sel;
        found = 1'b1;
      end
    end
  end

  // State, grant and round-robin history registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NUM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and combinational datapath steering.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    m_tdata  = s_tdata[DSIZE-1:0];
    m_tlast  = s_tlast[0];
    m_tvalid = 1'b0;
    s_tready = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCK;
          grant_d = win;
          last_d  = win;
        end
      end
      LOCK: begin
        m_tdata  = s_tdata[int'(grant_q)*DSIZE +: DSIZE];
        m_tlast  = s_tlast[grant_q];
        m_tvalid = s_tvalid[grant_q];
        s_tready = NUM'(m_tready) << grant_q;
        if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_tid = grant_q;
  assign busy  = (state_q == LOCK);

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Scoreboard bench for axi_stream_packet_arbiter (NUM=4, DSIZE=88).
// Per-requester source queues; monitor pops expected beats on handshake.
module tb_axi_stream_packet_arbiter;

  localparam int NUM   = 4;
  localparam int DSIZE = 88;
  localparam int IDW   = 2;

  typedef struct {
    logic [DSIZE-1:0] d;
    logic             l;
  } beat_t;

  typedef struct {
    int               tid;
    logic [DSIZE-1:0] d;
    logic             l;
    int               cyc;
  } exp_t;

  logic                 aclk;
  logic                 aresetn;
  logic [NUM*DSIZE-1:0] s_tdata;
  logic [NUM-1:0]       s_tvalid;
  logic [NUM-1:0]       s_tlast;
  logic [NUM-1:0]       s_tready;
  logic [DSIZE-1:0]     m_tdata;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic                 m_tready;
  logic [IDW-1:0]       m_tid;
  logic                 busy;

  beat_t srcq[NUM][$];
  exp_t  expq[$];
  logic  hold[NUM];
  logic  hs[NUM];
  logic  mr;
  int    cyc;
  int    checks;
  int    errors;
  int    c;

  axi_stream_packet_arbiter #(
    .NUM(NUM),
    .DSIZE(DSIZE),
    .IDW(IDW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tlast(m_tlast),
    .m_tready(m_tready),
    .m_tid(m_tid),
    .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Source driver: retire handshaken beats, present queue heads.
  initial begin
    beat_t tmp;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    forever begin
      @(negedge aclk);
      for (int i = 0; i < NUM; i++)
        hs[i] = s_tvalid[i] && s_tready[i];
      @(posedge aclk);
      #1;
      for (int i = 0; i < NUM; i++) begin
        if (hs[i] && srcq[i].size() > 0) tmp = srcq[i].pop_front();
        s_tvalid[i] = (srcq[i].size() > 0) && !hold[i];
        s_tlast[i]  = (srcq[i].size() > 0) ? srcq[i][0].l : 1'b0;
        s_tdata[i*DSIZE +: DSIZE] =
          (srcq[i].size() > 0) ? srcq[i][0].d : '0;
      end
      m_tready = mr;
    end
  end

  // Monitor: protocol invariants plus scoreboard pop on each transfer.
  always @(negedge aclk) begin
    exp_t e;
    if (busy)
      chk(s_tready == (NUM'(m_tready) << m_tid), "tready_route",
          96'(s_tready), 96'(NUM'(m_tready) << m_tid));
    else
      chk(s_tready == '0 && !m_tvalid, "idle_quiet",
          96'({m_tvalid, s_tready}), 96'(0));
    if (m_tvalid && m_tready) begin
      if (expq.size() == 0) begin
        chk(1'b0, "unexpected_beat", 96'(m_tdata), 96'(0));
      end else begin
        e = expq.pop_front();
        chk(m_tid == IDW'(e.tid) && m_tdata == e.d && m_tlast == e.l,
            "beat", {3'b0, m_tid, m_tlast, m_tdata},
            {3'b0, IDW'(e.tid), e.l, e.d});
        chk(cyc == e.cyc, "beat_cycle", 96'(cyc), 96'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic send(input int r, input int n, input int base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = DSIZE'(base + k);
      b.l = (k == n - 1);
      srcq[r].push_back(b);
    end
  endtask

  task automatic exp1(input int r, input int d, input bit l, input int cy);
    exp_t e;
    e.tid = r;
    e.d   = DSIZE'(d);
    e.l   = l;
    e.cyc = cy;
    expq.push_back(e);
  endtask

  task automatic expect_pkt(input int r, input int n, input int base,
                            input int c0, input int step);
    for (int k = 0; k < n; k++)
      exp1(r, base + k, k == n - 1, c0 + k * step);
  endtask

  task automatic clear_src();
    for (int i = 0; i < NUM; i++) begin
      srcq[i].delete();
      hold[i] = 1'b0;
      hs[i]   = 1'b0;
    end
  endtask

  task automatic do_reset();
    #1 aresetn = 1'b0;
    clear_src();
    tick(2);
    #1 aresetn = 1'b1;
    tick(1);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 300 && expq.size() > 0; k++) tick(1);
    chk(expq.size() == 0, nm, 96'(expq.size()), 96'(0));
    expq.delete();
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    mr      = 1'b1;
    aresetn = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      hold[i] = 1'b0;
      hs[i]   = 1'b0;
    end
    tick(2);
    chk(busy == 1'b0, "rst_busy", 96'(busy), 96'(0));
    chk(m_tvalid == 1'b0, "rst_mvalid", 96'(m_tvalid), 96'(0));
    chk(s_tready == '0, "rst_sready", 96'(s_tready), 96'(0));
    chk(m_tid == '0, "rst_mtid", 96'(m_tid), 96'(0));
    #1 aresetn = 1'b1;
    tick(1);

    // Single requester 2, three beats.
    c = cyc;
    send(2, 3, 'hA1);
    expect_pkt(2, 3, 'hA1, c + 2, 1);
    tick(1);
    chk(m_tvalid == 1'b0, "t1_arb_cycle", 96'(m_tvalid), 96'(0));
    tick(3);
    chk(busy == 1'b1, "t1_busy_last", 96'(busy), 96'(1));
    tick(1);
    chk(busy == 1'b0, "t1_busy_fall", 96'(busy), 96'(0));
    drain("t1_drain");

    // All four continuously requesting, two 2-beat packets each.
    do_reset();
    c = cyc;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NUM; i++) begin
        send(i, 2, 'hB000 + i * 256 + p * 16);
        expect_pkt(i, 2, 'hB000 + i * 256 + p * 16,
                   c + 2 + 3 * (p * NUM + i), 1);
      end
    drain("t2_drain");

    // Backpressure on a 4-beat packet from requester 1.
    c = cyc;
    send(1, 4, 'hC0);
    expect_pkt(1, 4, 'hC0, c + 2, 2);
    for (int k = 0; k < 7; k++) begin
      tick(1);
      mr = (k % 2 == 0);
    end
    drain("t3_drain");

    // Granted requester 0 stalls mid-packet; requester 3 waits.
    do_reset();
    c = cyc;
    send(0, 3, 'hD0);
    send(3, 1, 'hE0);
    exp1(0, 'hD0, 1'b0, c + 2);
    exp1(0, 'hD1, 1'b0, c + 8);
    exp1(0, 'hD2, 1'b1, c + 9);
    exp1(3, 'hE0, 1'b1, c + 11);
    tick(2);
    hold[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk(busy && m_tid == 2'd0 && !m_tvalid && !s_tready[3],
          "t4_grant_held", 96'({busy, m_tid, m_tvalid, s_tready[3]}),
          96'({1'b1, 2'd0, 1'b0, 1'b0}));
    end
    hold[0] = 1'b0;
    drain("t4_drain");

    // Simultaneous single-beat packets from 1 and 2.
    do_reset();
    c = cyc;
    send(1, 1, 'hF1);
    send(2, 1, 'hF2);
    exp1(1, 'hF1, 1'b1, c + 2);
    exp1(2, 'hF2, 1'b1, c + 4);
    tick(2);
    chk(busy == 1'b1, "t5_lock1", 96'(busy), 96'(1));
    tick(1);
    chk(busy == 1'b0, "t5_idle1", 96'(busy), 96'(0));
    tick(1);
    chk(busy == 1'b1, "t5_lock2", 96'(busy), 96'(1));
    tick(1);
    chk(busy == 1'b0, "t5_idle2", 96'(busy), 96'(0));
    drain("t5_drain");

    // Asynchronous reset during beat 2 of a 5-beat packet.
    do_reset();
    c = cyc;
    send(0, 5, 'h60);
    exp1(0, 'h60, 1'b0, c + 2);
    exp1(0, 'h61, 1'b0, c + 3);
    tick(3);
    #2 aresetn = 1'b0;
    #1;
    chk(m_tvalid == 1'b0, "t6_async_mvalid", 96'(m_tvalid), 96'(0));
    chk(s_tready == '0, "t6_async_sready", 96'(s_tready), 96'(0));
    chk(busy == 1'b0, "t6_async_busy", 96'(busy), 96'(0));
    clear_src();
    tick(2);
    #1 aresetn = 1'b1;
    tick(1);
    chk(expq.size() == 0, "t6_partial", 96'(expq.size()), 96'(0));
    c = cyc;
    send(0, 1, 'h70);
    send(3, 1, 'h73);
    exp1(0, 'h70, 1'b1, c + 2);
    exp1(3, 'h73, 1'b1, c + 4);
    drain("t6_drain");

    for (int i = 0; i < NUM; i++)
      chk(srcq[i].size() == 0, "src_empty", 96'(srcq[i].size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
